// File: rtl/apb_req_master_pkg.sv
// Shared types and constants for the APB request master: FSM state encoding,
// the registered response record and the data returned on a timed-out access.
package apb_req_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/apb_req_timeout_cnt.sv
// ACCESS-phase watchdog for apb_req_master (built only with
// APB_REQ_MASTER_TIMEOUT_EN). Counts stalled ACCESS cycles and flags the cycle
// on which the stall count reaches LIMIT.
module apb_req_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Stall counter: restarts for every transfer, advances on each stalled ACCESS cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The stalled cycle that would bring the count to LIMIT is the abort cycle.
    assign expired = count_en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_req_master.sv
// Core request/grant/rvalid to APB3 master bridge, one transfer in flight.
// Optional ACCESS timeout is enabled by defining APB_REQ_MASTER_TIMEOUT_EN.
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_i,
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      we_q;
    logic [31:0]               wdata_q;
    resp_t                     resp_q, resp_d;
    logic                      rvalid_q, rvalid_d;
    logic                      accept;
    logic                      in_access;
    logic                      done;
    logic                      timeout_hit;
    logic                      unused_addr;

    assign accept    = req_i && (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign done      = in_access && PREADY;

    // Only the low address bits reach the APB bus.
    assign unused_addr = ^addr_i[31:APB_ADDR_WIDTH];

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    apb_req_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .clear    (state_q == SETUP),
        .count_en (in_access && !PREADY),
        .expired  (timeout_hit)
    );
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // FSM state register; async reset drops PSEL/PENABLE immediately.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one transfer at a time, ACCESS held until PREADY or timeout.
    // NOTE: the default assignment at the top keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on acceptance; read transfers carry zero write data.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr_i[APB_ADDR_WIDTH-1:0];
            we_q    <= we_i;
            wdata_q <= we_i ? wdata_i : 32'h0;
        end
    end

    // Response selection: normal completion beats timeout, zeros otherwise.
    always_comb begin
        resp_d   = '0;
        rvalid_d = 1'b0;
        if (done) begin
            rvalid_d     = 1'b1;
            resp_d.rdata = we_q ? 32'h0 : PRDATA;
            resp_d.err   = PSLVERR;
        end else if (timeout_hit) begin
            rvalid_d     = 1'b1;
            resp_d.rdata = TIMEOUT_RDATA;
            resp_d.err   = 1'b1;
        end
    end

    // One-cycle response pulse landing in the first IDLE cycle after completion.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rvalid_q <= 1'b0;
            resp_q   <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            resp_q   <= resp_d;
        end
    end

    assign gnt_o    = accept;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = resp_q.rdata;
    assign err_o    = resp_q.err;
    assign PSEL     = (state_q != IDLE);
    assign PENABLE  = in_access;
    assign PADDR    = addr_q;
    assign PWRITE   = we_q;
    assign PWDATA   = wdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: directed transfers, a cycle-count
// reference model compared every cycle, plus literal latency/data checks.
// Timeout scenarios run when APB_REQ_MASTER_TIMEOUT_EN is defined.
module tb_apb_req_master;

    localparam int AW = 12;
    localparam int TO = 8;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          HCLK;
    logic          HRESETn;
    logic          req_i;
    logic [31:0]   addr_i;
    logic          we_i;
    logic [31:0]   wdata_i;
    logic          gnt_o;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    apb_req_master #(
        .APB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is "active" from the accept edge until the
    // edge that completes it; age 1 is the SETUP cycle, age >= 2 is ACCESS.
    bit          m_active;
    int          m_age;
    logic [AW-1:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    bit          m_rv;
    logic [31:0] m_rdata;
    logic        m_err;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_active = 0; m_age = 0; m_addr = '0; m_we = 0; m_wdata = '0;
            m_rv = 0; m_rdata = '0; m_err = 0;
        end else begin
            m_rv = 0; m_rdata = '0; m_err = 0;
            if (!m_active) begin
                if (req_i) begin
                    m_active = 1; m_age = 1;
                    m_addr = addr_i[AW-1:0]; m_we = we_i;
                    m_wdata = we_i ? wdata_i : 32'h0;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (PREADY) begin
                m_active = 0; m_rv = 1;
                m_rdata = m_we ? 32'h0 : PRDATA;
                m_err = PSLVERR;
            end else if (TO_EN && (m_age - 1) == TO) begin
                m_active = 0; m_rv = 1; m_err = 1;
            end else begin
                m_age++;
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge HCLK) begin
        check("gnt",     32'(gnt_o),    32'(!m_active && req_i));
        check("psel",    32'(PSEL),     32'(m_active));
        check("penable", 32'(PENABLE),  32'(m_active && m_age >= 2));
        check("rvalid",  32'(rvalid_o), 32'(m_rv));
        check("rdata",   rdata_o,       m_rdata);
        check("err",     32'(err_o),    32'(m_err));
        if (m_active) begin
            check("paddr",  32'(PADDR),  32'(m_addr));
            check("pwrite", 32'(PWRITE), 32'(m_we));
            check("pwdata", PWDATA,      m_wdata);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK); #1;
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that starts the response cycle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int nwait, input logic [31:0] rd, input logic se,
                        input bit abort, input bit hold, output int lat);
        int g;
        req_i = 1'b1; addr_i = a; we_i = w; wdata_i = wd;
        g = cyc;
        #1 check("gnt_lit", 32'(gnt_o), 32'd1);
        @(posedge HCLK); #1;
        req_i = hold; addr_i = 32'hFFFF_FFFF; wdata_i = ~wd; we_i = ~w;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hBAD0_BAD0;
        @(posedge HCLK); #1;
        for (int i = 0; i < nwait; i++) begin
            PREADY = 1'b0; PSLVERR = 1'b0;
            @(posedge HCLK); #1;
        end
        if (!abort) begin
            PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
            @(posedge HCLK); #1;
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        lat = cyc - g;
    endtask

    task automatic check_resp(input string name, input logic [31:0] rd, input logic e,
                              input int lat, input int exp_lat);
        check({name, "_rvalid"}, 32'(rvalid_o), 32'd1);
        check({name, "_rdata"},  rdata_o, rd);
        check({name, "_err"},    32'(err_o), 32'(e));
        check({name, "_lat"},    32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int lat;
        HRESETn = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #2;
        check("rst_psel",    32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_rvalid",  32'(rvalid_o), 32'd0);
        check("rst_rdata",   rdata_o, 32'd0);
        check("rst_err",     32'(err_o), 32'd0);
        check("rst_paddr",   32'(PADDR), 32'd0);
        check("rst_pwdata",  PWDATA, 32'd0);
        check("rst_pwrite",  32'(PWRITE), 32'd0);
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // PREADY/PSLVERR toggling in IDLE must have no effect.
        PREADY = 1'b1; PSLVERR = 1'b1;
        idle(2);
        PREADY = 1'b0; PSLVERR = 1'b0;

        // Zero-wait write.
        xfer(32'h0000_0004, 1'b1, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0, 1'b0, lat);
        check_resp("wr0", 32'h0, 1'b0, lat, 3);
        idle(1);

        // Read with 4 wait states.
        xfer(32'h0000_0008, 1'b0, 32'h5555_AAAA, 4, 32'h0000_0C81, 1'b0, 1'b0, 1'b0, lat);
        check_resp("rd4", 32'h0000_0C81, 1'b0, lat, 7);
        idle(1);

        // Slave error, then a clean transfer issued back-to-back.
        xfer(32'h0000_000C, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, lat);
        check_resp("slverr", 32'hDEAD_BEEF, 1'b1, lat, 4);
        xfer(32'h0000_0010, 1'b0, 32'h0, 0, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, lat);
        check_resp("after_err", 32'h0000_00A5, 1'b0, lat, 3);
        idle(2);

        // Back-to-back with req_i held high; upper address bits must be dropped.
        xfer(32'hABCD_1FFC, 1'b1, 32'hCAFE_0001, 0, 32'h0, 1'b0, 1'b0, 1'b1, lat);
        check_resp("b2b0", 32'h0, 1'b0, lat, 3);
        xfer(32'h0000_0020, 1'b0, 32'h0, 0, 32'h0000_0777, 1'b0, 1'b0, 1'b1, lat);
        check_resp("b2b1", 32'h0000_0777, 1'b0, lat, 3);
        xfer(32'h0000_0024, 1'b1, 32'hCAFE_0003, 0, 32'h0, 1'b0, 1'b0, 1'b0, lat);
        check_resp("b2b2", 32'h0, 1'b0, lat, 3);
        idle(2);

        // Reset while in ACCESS.
        req_i = 1'b1; addr_i = 32'h0000_0030; we_i = 1'b1; wdata_i = 32'h0BAD_F00D;
        @(posedge HCLK); #1;
        req_i = 1'b0;
        @(posedge HCLK); #1;
        PREADY = 1'b0;
        #1 check("pre_rst_penable", 32'(PENABLE), 32'd1);
        #1 HRESETn = 1'b0;
        #1;
        check("mid_rst_psel",    32'(PSEL), 32'd0);
        check("mid_rst_penable", 32'(PENABLE), 32'd0);
        @(posedge HCLK); #1;
        check("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
        #2 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(32'h0000_0034, 1'b0, 32'h0, 2, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0, lat);
        check_resp("post_rst", 32'h1357_9BDF, 1'b0, lat, 5);
        idle(2);

`ifdef APB_REQ_MASTER_TIMEOUT_EN
        // PREADY never arrives: abort after TO stalled ACCESS cycles.
        xfer(32'h0000_0040, 1'b0, 32'h0, TO, 32'h0, 1'b0, 1'b1, 1'b0, lat);
        check_resp("timeout", 32'h0, 1'b1, lat, 10);
        idle(1);
        // PREADY on the last permitted ACCESS cycle: normal completion.
        xfer(32'h0000_0044, 1'b0, 32'h0, TO - 1, 32'h0000_4444, 1'b0, 1'b0, 1'b0, lat);
        check_resp("to_edge", 32'h0000_4444, 1'b0, lat, 10);
        idle(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_req_master.md
Name: apb_req_master

Overview:
- Converts a core-side request/grant/rvalid bus into APB3 master transfers that drive the 4 KB APB register slaves on the peripheral bus.
- Handles one outstanding transfer at a time, with SETUP/ACCESS sequencing, PREADY wait states and PSLVERR reporting.
- Sits between the peripheral interconnect and the APB slave decoder.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR; the low APB_ADDR_WIDTH bits of addr_i are forwarded.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; used only with APB_REQ_MASTER_TIMEOUT_EN.

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  reset, asynchronous, active-low
- req_i  input  1  core request valid
- addr_i  input  32  byte address
- we_i  input  1  1 = write, 0 = read
- wdata_i  input  32  write data
- gnt_o  output  1  request accepted this cycle
- rvalid_o  output  1  one-cycle response pulse
- rdata_o  output  32  read data, valid with rvalid_o
- err_o  output  1  error flag, valid with rvalid_o
- PADDR  output  APB_ADDR_WIDTH  APB address
- PWDATA  output  32  APB write data
- PWRITE  output  1  APB direction
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PRDATA  input  32  APB read data
- PREADY  input  1  APB slave ready
- PSLVERR  input  1  APB slave error

Behaviour:
- Clock and reset: clock HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; address, data and direction registers 0.
- FSM states and transitions:
  - IDLE -> SETUP when req_i = 1.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE when PREADY = 1.
  - ACCESS -> ACCESS when PREADY = 0.
- Grant: gnt_o = req_i while in IDLE (combinational). A request is accepted on the cycle req_i && gnt_o. On acceptance, latch addr_i[APB_ADDR_WIDTH-1:0], we_i and wdata_i.
- SETUP: PSEL = 1, PENABLE = 0.
- ACCESS: PSEL = 1, PENABLE = 1.
- Stability: PADDR, PWRITE and PWDATA are driven from the latched registers and stay stable from SETUP through the final ACCESS cycle. PWDATA = 0 for reads.
- Completion: on the ACCESS cycle with PREADY = 1:
  - capture PRDATA for reads, or 0 for writes, into rdata_o;
  - capture PSLVERR into err_o;
  - pulse rvalid_o for exactly one cycle on the following cycle, which is the first IDLE cycle.
- Outside the response cycle, rdata_o and err_o are 0.
- Latency: acceptance -> rvalid_o is 3 cycles with zero wait states, plus N cycles for N wait states.
- Back-to-back: a new request may be granted in the same cycle rvalid_o is high. Peak throughput is one transfer per 3 cycles.
- No byte strobes. Address bits pass through unmodified; alignment is the core's responsibility.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronous), no rvalid_o is issued, and the FSM restarts in IDLE.
- Signals ignored outside their phase: PREADY and PSLVERR in IDLE and SETUP; req_i outside IDLE.

Optional Feature:
- Macro: APB_REQ_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES, the FSM returns to IDLE, PSEL and PENABLE deassert, and rvalid_o pulses next cycle with err_o = 1 and rdata_o = 0.
  - If PREADY = 1 arrives in the same cycle the limit is reached, PREADY wins and the transfer completes normally.
- When undefined: no counter is built and ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_req_master_pkg holds:
  - the FSM state enum typedef (IDLE, SETUP, ACCESS);
  - the response record typedef (rdata, err);
  - the timeout error data constant 32'h0.
- Sub-module apb_req_timeout_cnt (counter plus compare, instantiated only under the macro) is natural; the FSM stays in the top module.

Test Plan:
- Zero-wait write: req_i with addr 0x004, wdata 0x1234_5678, PREADY tied 1 -> PSEL high for 2 cycles, PENABLE high on the 2nd; PADDR = 0x004, PWDATA = 0x1234_5678; rvalid_o 3 cycles after grant with err_o = 0 and rdata_o = 0.
- Read with 4 wait states: addr 0x008, slave returns PRDATA 0x0000_0C81 after 4 PREADY-low cycles -> rvalid_o at cycle 7 with rdata_o = 0x0000_0C81; PADDR and PWRITE stable throughout.
- Slave error: read with PSLVERR = 1 in the PREADY cycle -> err_o = 1 together with rvalid_o; the next transfer reports err_o = 0.
- Back-to-back: req_i held high for 3 requests -> grants 3 cycles apart; each rvalid_o coincides with the next grant; no gap in the PSEL pattern beyond the IDLE cycle.
- Reset mid-ACCESS: assert HRESETn low while PENABLE = 1 -> PSEL and PENABLE are 0 in the same cycle, no rvalid_o; the first request after release completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES = 8): PREADY held 0 -> abort after 8 ACCESS cycles, rvalid_o with err_o = 1 and rdata_o = 0. Repeat with PREADY rising on the 8th cycle -> normal completion with err_o = 0.
